// File: rtl/iob_axis2axi_out_sched_if.sv
// ----------------------------------------------------------------------------
// iob_axis2axi_out_sched_if
//  Descriptor handshake bundle (valid/ready plus word address and word length)
//  shared by the scheduler's descriptor input and its engine config output.
//
//  Signals
//   valid   descriptor offered by the master side
//   ready   slave side accepts the descriptor when valid & ready
//   addr    start byte address, 4-byte aligned
//   length  transfer length in 32-bit words
//
//  Modports
//   master  drives valid/addr/length, observes ready
//   slave   observes valid/addr/length, drives ready
// ----------------------------------------------------------------------------
interface iob_axis2axi_out_sched_if #(
    parameter int ADDR_W = 24
) ();
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] length;

    modport master (output valid, output addr, output length, input ready);
    modport slave  (input valid, input addr, input length, output ready);
endinterface

// File: rtl/iob_axis2axi_out_sched.sv
// ----------------------------------------------------------------------------
// iob_axis2axi_out_sched
//  Descriptor scheduler in front of the AXI-read-to-AXIS engine. Buffers up to
//  2**QUEUE_W read descriptors, hands them to the engine one at a time and
//  retires each one once the engine has delivered all of its words, so that
//  software can queue back-to-back reads without polling the engine.
//
//  Ports
//   clk_i        clock
//   cke_i        clock enable, all registers hold while low
//   arst_n_i     asynchronous active-low reset
//   desc_if      slave  : descriptor push (valid/ready/addr/length)
//   cfg_if       master : descriptor offered to the engine config port
//   beat_i       engine AXIS handshake (axis_out_valid & axis_out_ready)
//   flush_i      drop every queued, not-yet-issued descriptor
//   clr_err_i    clear error_o
//   busy_o       queue non-empty or scheduler not idle
//   level_o      queue occupancy
//   done_o       one-cycle pulse per retired descriptor
//   completed_o  retired-descriptor count, wraps
//   error_o      sticky, beat_i seen while no descriptor was running
// ----------------------------------------------------------------------------
module iob_axis2axi_out_sched #(
    parameter int AXI_ADDR_W = 24,
    parameter int QUEUE_W    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    arst_n_i,
    iob_axis2axi_out_sched_if.slave  desc_if,
    iob_axis2axi_out_sched_if.master cfg_if,
    input  logic                    beat_i,
    input  logic                    flush_i,
    input  logic                    clr_err_i,
    output logic                    busy_o,
    output logic [QUEUE_W:0]        level_o,
    output logic                    done_o,
    output logic [CNT_W-1:0]        completed_o,
    output logic                    error_o
);

    localparam int DEPTH = 2 ** QUEUE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [AXI_ADDR_W-1:0] addr_mem [DEPTH];
    logic [AXI_ADDR_W-1:0] len_mem  [DEPTH];
    logic [QUEUE_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [QUEUE_W:0]      level_q;

    logic [AXI_ADDR_W-1:0] out_addr_q, out_len_q, remaining_q;
    logic                  out_valid_q;
    logic                  done_q;
    logic                  error_q;
    logic [CNT_W-1:0]      completed_q;

    logic full, empty, push, last_beat, err_set;
    logic pop, set_valid, start_run, retire;

    assign full  = (level_q == (QUEUE_W+1)'(DEPTH));
    assign empty = (level_q == '0);

    // Zero-length descriptors still see ready (they are accepted) but are
    // never written into the queue, so they are silently discarded.
    assign desc_if.ready = !full && !flush_i;
    assign push          = desc_if.valid && desc_if.ready && (desc_if.length != '0);

    assign last_beat = beat_i && (remaining_q == AXI_ADDR_W'(1));
    assign err_set   = beat_i && (state_q != RUN);

    // Next-state and control strobes. A descriptor popped from IDLE raises
    // valid one cycle later (ISSUE sets it), whereas a pop on the last beat
    // of the running descriptor raises valid immediately so that the next
    // descriptor is offered the cycle after that beat.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        set_valid = 1'b0;
        start_run = 1'b0;
        retire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!out_valid_q) begin
                    set_valid = 1'b1;
                end else if (cfg_if.ready) begin
                    start_run = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (last_beat) begin
                    retire = 1'b1;
                    if (!empty) begin
                        pop       = 1'b1;
                        set_valid = 1'b1;
                        state_d   = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
        end else if (cke_i) begin
            state_q <= state_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (cke_i && push) begin
            addr_mem[wr_ptr_q] <= desc_if.addr;
            len_mem[wr_ptr_q]  <= desc_if.length;
        end
    end

    // Flush wins over push/pop bookkeeping: push is already blocked by
    // desc_ready, and a head popped in the same cycle has been captured in
    // the output registers, so dropping the rest is just a pointer move.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (cke_i) begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + QUEUE_W'(1);
            end
            if (flush_i) begin
                rd_ptr_q <= wr_ptr_q;
                level_q  <= '0;
            end else begin
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + QUEUE_W'(1);
                end
                unique case ({push, pop})
                    2'b10:   level_q <= level_q + (QUEUE_W+1)'(1);
                    2'b01:   level_q <= level_q - (QUEUE_W+1)'(1);
                    default: level_q <= level_q;
                endcase
            end
        end
    end

    // Issued descriptor, beat tracking, completion and error status.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            out_addr_q  <= '0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            completed_q <= '0;
            error_q     <= 1'b0;
        end else if (cke_i) begin
            if (pop) begin
                out_addr_q <= addr_mem[rd_ptr_q];
                out_len_q  <= len_mem[rd_ptr_q];
            end
            if (set_valid) begin
                out_valid_q <= 1'b1;
            end else if (start_run) begin
                out_valid_q <= 1'b0;
            end
            if (start_run) begin
                remaining_q <= out_len_q;
            end else if (state_q == RUN && beat_i && remaining_q != '0) begin
                remaining_q <= remaining_q - AXI_ADDR_W'(1);
            end
            done_q <= retire;
            if (retire) begin
                completed_q <= completed_q + CNT_W'(1);
            end
            if (err_set) begin
                error_q <= 1'b1;
            end else if (clr_err_i) begin
                error_q <= 1'b0;
            end
        end
    end

    assign cfg_if.valid  = out_valid_q;
    assign cfg_if.addr   = out_addr_q;
    assign cfg_if.length = out_len_q;
    assign busy_o        = (level_q != '0) || (state_q != IDLE);
    assign level_o       = level_q;
    assign done_o        = done_q;
    assign completed_o   = completed_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_iob_axis2axi_out_sched.sv
// ----------------------------------------------------------------------------
// tb_iob_axis2axi_out_sched
//  Directed scenarios followed by a randomized phase. Pushed descriptors are
//  queued as expected engine configs; a monitor compares every config
//  handshake against that queue, counts delivered words per issued
//  descriptor to predict done/completed, and predicts the sticky error flag.
// ----------------------------------------------------------------------------
module tb_iob_axis2axi_out_sched;

    localparam int AW = 24;
    localparam int QW = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          cke, arst_n, beat, flush, clr_err;
    logic          busy, done, error;
    logic [QW:0]   level;
    logic [CW-1:0] completed;

    logic          man_ready, man_beat, eng_auto;
    logic          eng_ready, eng_beat, eng_busy;
    logic [AW-1:0] eng_rem;

    int checks   = 0;
    int failures = 0;
    int done_pulses = 0;

    logic [2*AW-1:0] exp_cfg_q [$];
    logic [CW-1:0]   done_q [$];
    logic            m_active, m_err;
    logic [AW-1:0]   m_len, m_words;
    logic [CW-1:0]   m_completed;
    logic [2*AW-1:0] mon_e;
    logic [CW-1:0]   mon_c;

    iob_axis2axi_out_sched_if #(.ADDR_W(AW)) desc_if ();
    iob_axis2axi_out_sched_if #(.ADDR_W(AW)) cfg_if ();

    assign cfg_if.ready = eng_auto ? eng_ready : man_ready;
    assign beat         = eng_auto ? eng_beat  : man_beat;

    always #5 clk = ~clk;

    iob_axis2axi_out_sched #(
        .AXI_ADDR_W(AW),
        .QUEUE_W   (QW),
        .CNT_W     (CW)
    ) dut (
        .clk_i      (clk),
        .cke_i      (cke),
        .arst_n_i   (arst_n),
        .desc_if    (desc_if),
        .cfg_if     (cfg_if),
        .beat_i     (beat),
        .flush_i    (flush),
        .clr_err_i  (clr_err),
        .busy_o     (busy),
        .level_o    (level),
        .done_o     (done),
        .completed_o(completed),
        .error_o    (error)
    );

    task automatic checkOutput(input string name, input logic [47:0] actual,
                               input logic [47:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Holds a descriptor on the push port until accepted (leaves valid high).
    task automatic applyStimulus(input logic [AW-1:0] a, input logic [AW-1:0] l,
                                 output bit accepted);
        desc_if.valid  = 1'b1;
        desc_if.addr   = a;
        desc_if.length = l;
        accepted       = 1'b0;
        for (int n = 0; n < 300 && !accepted; n++) begin
            @(negedge clk);
            if (desc_if.ready === 1'b1) accepted = 1'b1;
            else tick();
        end
        if (accepted) begin
            if (l != '0) exp_cfg_q.push_back({a, l});
            tick();
        end else begin
            checkOutput("push_timeout", 0, 1);
        end
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        while ((busy || eng_busy) && n < limit) begin
            sample();
            n++;
        end
        if (busy || eng_busy) checkOutput("idle_timeout", 0, 1);
        tick();
    endtask

    task automatic waitValid(input int limit);
        int n = 0;
        while (cfg_if.valid !== 1'b1 && n < limit) begin
            sample();
            n++;
        end
        if (cfg_if.valid !== 1'b1) checkOutput("valid_timeout", 0, 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_desc_ready"}, desc_if.ready, 1);
        checkOutput({tag, "_cfg_valid"}, cfg_if.valid, 0);
        checkOutput({tag, "_cfg_addr"}, cfg_if.addr, 0);
        checkOutput({tag, "_cfg_length"}, cfg_if.length, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_level"}, level, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_completed"}, completed, 0);
        checkOutput({tag, "_error"}, error, 0);
    endtask

    // Engine stand-in: accepts a config when idle (random ready), then emits
    // exactly 'length' beats with random gaps.
    initial begin
        logic          s_hs, s_beat;
        logic [AW-1:0] s_len;
        eng_ready = 1'b0;
        eng_beat  = 1'b0;
        eng_busy  = 1'b0;
        eng_rem   = '0;
        forever begin
            @(negedge clk);
            s_hs   = cfg_if.valid && cfg_if.ready;
            s_beat = beat;
            s_len  = cfg_if.length;
            tick();
            if (!eng_auto || !arst_n) begin
                eng_busy  = 1'b0;
                eng_ready = 1'b0;
                eng_beat  = 1'b0;
            end else if (!eng_busy) begin
                if (s_hs) begin
                    eng_busy  = 1'b1;
                    eng_rem   = s_len;
                    eng_ready = 1'b0;
                    eng_beat  = ($urandom_range(0, 3) != 0);
                end else begin
                    eng_ready = ($urandom_range(0, 2) != 0);
                end
            end else begin
                if (s_beat) eng_rem = eng_rem - 1'b1;
                if (eng_rem == '0) begin
                    eng_busy  = 1'b0;
                    eng_beat  = 1'b0;
                    eng_ready = ($urandom_range(0, 2) != 0);
                end else begin
                    eng_beat = ($urandom_range(0, 3) != 0);
                end
            end
        end
    end

    // Scoreboard monitor: checks outputs against predictions made from the
    // previous cycle, then advances the reference model with this cycle's
    // inputs and handshakes.
    always @(negedge clk) begin
        if (!arst_n) begin
            exp_cfg_q.delete();
            done_q.delete();
            m_active    = 1'b0;
            m_err       = 1'b0;
            m_len       = '0;
            m_words     = '0;
            m_completed = '0;
        end else begin
            if (done_q.size() != 0) begin
                mon_c = done_q.pop_front();
                checkOutput("done_pulse", done, 1);
                checkOutput("completed_at_done", completed, mon_c);
            end else begin
                checkOutput("no_extra_done", done, 0);
            end
            if (done === 1'b1) done_pulses++;
            checkOutput("error_flag", error, m_err);

            if (beat && !m_active) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;

            if (cfg_if.valid && cfg_if.ready) begin
                if (exp_cfg_q.size() == 0) begin
                    checkOutput("unexpected_issue", 1, 0);
                end else begin
                    mon_e = exp_cfg_q.pop_front();
                    checkOutput("issue_addr", cfg_if.addr, mon_e[2*AW-1:AW]);
                    checkOutput("issue_length", cfg_if.length, mon_e[AW-1:0]);
                    m_active = 1'b1;
                    m_len    = mon_e[AW-1:0];
                    m_words  = '0;
                end
            end else if (beat && m_active) begin
                m_words = m_words + 1'b1;
                if (m_words == m_len) begin
                    m_active    = 1'b0;
                    m_completed = m_completed + 1'b1;
                    done_q.push_back(m_completed);
                end
            end
        end
    end

    initial begin
        bit            acc;
        int            pulses0;
        int            nz;
        logic [AW-1:0] ra, rl;

        cke = 1'b1; arst_n = 1'b0; flush = 1'b0; clr_err = 1'b0;
        man_ready = 1'b0; man_beat = 1'b0; eng_auto = 1'b0;
        desc_if.valid = 1'b0; desc_if.addr = '0; desc_if.length = '0;

        repeat (3) tick();
        checkResetValues("reset");
        arst_n = 1'b1;
        repeat (2) tick();

        // 1: single descriptor, valid two cycles after acceptance
        man_ready = 1'b1;
        applyStimulus(24'h001000, 24'd4, acc);
        desc_if.valid = 1'b0;
        sample();
        checkOutput("t1_valid_e0", cfg_if.valid, 0);
        tick(); sample();
        checkOutput("t1_valid_e1", cfg_if.valid, 0);
        tick(); sample();
        checkOutput("t1_valid_e2", cfg_if.valid, 1);
        tick();
        man_ready = 1'b0;
        man_beat  = 1'b1;
        repeat (4) tick();
        man_beat = 1'b0;
        sample();
        checkOutput("t1_done", done, 1);
        checkOutput("t1_completed", completed, 1);
        checkOutput("t1_busy", busy, 0);
        tick(); sample();
        checkOutput("t1_done_once", done, 0);
        tick();

        // 2: fill queue while engine stalls
        for (int i = 0; i < 5; i++) begin
            applyStimulus(24'h010000 + 24'(i * 16), 24'($urandom_range(1, 4)), acc);
        end
        desc_if.addr   = 24'h0F0000;
        desc_if.length = 24'd2;
        sample();
        checkOutput("t2_full_ready", desc_if.ready, 0);
        checkOutput("t2_level", level, 4);
        checkOutput("t2_head_valid", cfg_if.valid, 1);
        tick();
        desc_if.valid = 1'b0;
        eng_auto = 1'b1;
        waitIdle(2000);
        eng_auto = 1'b0;
        sample();
        checkOutput("t2_completed", completed, 6);
        tick();

        // 3: back-to-back descriptors
        pulses0   = done_pulses;
        man_ready = 1'b1;
        applyStimulus(24'h000000, 24'd3, acc);
        applyStimulus(24'h002000, 24'd2, acc);
        desc_if.valid = 1'b0;
        waitValid(20);
        tick();
        man_beat = 1'b1;
        repeat (3) tick();
        man_beat = 1'b0;
        sample();
        checkOutput("t3_b2b_valid", cfg_if.valid, 1);
        tick();
        man_beat = 1'b1;
        repeat (2) tick();
        man_beat  = 1'b0;
        man_ready = 1'b0;
        sample();
        tick(); sample();
        checkOutput("t3_completed", completed, 8);
        checkOutput("t3_busy", busy, 0);
        checkOutput("t3_done_pulses", done_pulses - pulses0, 2);
        tick();

        // 4: zero-length descriptor is accepted and dropped
        applyStimulus(24'h000040, 24'd0, acc);
        desc_if.valid = 1'b0;
        checkOutput("t4_accepted", acc, 1);
        sample();
        checkOutput("t4_level", level, 0);
        tick(); sample();
        tick(); sample();
        checkOutput("t4_no_valid", cfg_if.valid, 0);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_completed", completed, 8);
        tick();

        // 5: flush with the head already issued
        pulses0 = done_pulses;
        applyStimulus(24'h000100, 24'd2, acc);
        applyStimulus(24'h000200, 24'd3, acc);
        applyStimulus(24'h000300, 24'd1, acc);
        applyStimulus(24'h000400, 24'd5, acc);
        desc_if.valid = 1'b0;
        sample();
        checkOutput("t5_level_before", level, 3);
        checkOutput("t5_head_valid", cfg_if.valid, 1);
        tick();
        flush = 1'b1;
        while (exp_cfg_q.size() > 1) void'(exp_cfg_q.pop_back());
        sample();
        checkOutput("t5_flush_ready", desc_if.ready, 0);
        tick();
        flush = 1'b0;
        sample();
        checkOutput("t5_level_after", level, 0);
        checkOutput("t5_valid_kept", cfg_if.valid, 1);
        checkOutput("t5_addr_kept", cfg_if.addr, 24'h000100);
        tick();
        eng_auto = 1'b1;
        waitIdle(500);
        eng_auto = 1'b0;
        sample();
        checkOutput("t5_completed", completed, 9);
        checkOutput("t5_done_pulses", done_pulses - pulses0, 1);
        tick();

        // 6: error on stray beat, clear, then reset mid-run
        man_beat = 1'b1;
        tick();
        man_beat = 1'b0;
        sample();
        checkOutput("t6_error_set", error, 1);
        tick(); tick(); sample();
        checkOutput("t6_error_sticky", error, 1);
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        sample();
        checkOutput("t6_error_clr", error, 0);
        tick();
        man_ready = 1'b1;
        applyStimulus(24'h003000, 24'd8, acc);
        desc_if.valid = 1'b0;
        waitValid(20);
        tick();
        man_ready = 1'b0;
        man_beat  = 1'b1;
        repeat (2) tick();
        sample();
        checkOutput("t6_busy_mid_run", busy, 1);
        #2;
        arst_n   = 1'b0;
        man_beat = 1'b0;
        #1;
        checkResetValues("midrun_reset");
        tick(); tick();
        arst_n = 1'b1;
        repeat (2) tick();

        // randomized traffic against the reference model
        eng_auto = 1'b1;
        nz = 0;
        for (int i = 0; i < 40; i++) begin
            ra = 24'($urandom) & 24'hFFFFFC;
            rl = 24'($urandom_range(0, 6));
            applyStimulus(ra, rl, acc);
            desc_if.valid = 1'b0;
            if (acc && rl != '0) nz++;
            repeat ($urandom_range(0, 2)) tick();
        end
        waitIdle(4000);
        sample();
        checkOutput("rand_completed", completed, 16'(nz));
        checkOutput("rand_queue_drained", exp_cfg_q.size(), 0);
        checkOutput("rand_level", level, 0);
        eng_auto = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
